// File: rtl/riscv_pkg.sv
// Types shared between the pipeline MEM stage and the data RAM.
// Access-size encoding plus a helper that masks load data to the access width.
package riscv_pkg;

   typedef enum logic [1:0] {
      MEM_B   = 2'b00,
      MEM_H   = 2'b01,
      MEM_W   = 2'b10,
      MEM_RSV = 2'b11
   } mem_size_t;

   function automatic logic [31:0] size_mask(input mem_size_t size);
      case (size)
         MEM_B:   return 32'h0000_00FF;
         MEM_H:   return 32'h0000_FFFF;
         MEM_W:   return 32'hFFFF_FFFF;
         default: return 32'h0000_0000;
      endcase
   endfunction

endpackage

// File: rtl/dmem_lane_ctrl.sv
// Byte-lane steering for the data RAM: write strobes, lane-shifted store data,
// misalignment detection and the bit shift used to right-justify loads.
module dmem_lane_ctrl
   import riscv_pkg::*;
(
   input  logic [1:0]  size,
   input  logic [1:0]  offset,
   input  logic [31:0] store_data,
   output logic [3:0]  strobe,
   output logic [31:0] lane_data,
   output logic [4:0]  shift,
   output logic        misaligned
);

   // NOTE: every output gets a default before the case so no path leaves a
   // value unassigned, which would otherwise infer a latch.
   always_comb begin
      strobe     = 4'b0000;
      misaligned = 1'b0;
      shift      = {offset, 3'b000};
      lane_data  = store_data << shift;
      case (mem_size_t'(size))
         MEM_B: strobe = 4'b0001 << offset;
         MEM_H: begin
            strobe     = 4'b0011 << offset;
            misaligned = offset[0];
         end
         MEM_W: begin
            strobe     = 4'b1111;
            misaligned = (offset != 2'b00);
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/data_memory.sv
// Byte-addressable data RAM responding to the MEM stage: combinational loads,
// byte-lane stores, access-fault detection, sticky fault status and counters.
module data_memory
   import riscv_pkg::*;
#(
   parameter int          ADDR_WIDTH = 12,
   parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_clk_en,
   input  logic [31:0]           i_data_addr,
   input  logic [31:0]           i_data_wr,
   input  logic [1:0]            i_data_rd_en_ctrl,
   input  logic                  i_data_rd_en,
   input  logic                  i_data_wr_en,
   output logic [31:0]           o_data_rd,
   output logic                  o_access_fault,
   output logic                  o_fault_sticky,
   output logic [31:0]           o_fault_addr,
   input  logic                  i_fault_clr,
   output logic [15:0]           o_load_count,
   output logic [15:0]           o_store_count,
   input  logic                  i_init_we,
   input  logic [ADDR_WIDTH-3:0] i_init_addr,
   input  logic [31:0]           i_init_data
);

   localparam int WORDS = 2 ** (ADDR_WIDTH - 2);

   logic [31:0]           mem [WORDS];
   logic [31:0]           rel_addr;
   logic [ADDR_WIDTH-3:0] word_idx;
   logic                  in_range;
   logic                  req;
   logic                  rsv;
   logic [3:0]            strobe;
   logic [31:0]           lane_data;
   logic [4:0]            shift;
   logic                  misaligned;
   logic                  run;
   logic                  active;
   logic                  load_ok;
   logic                  store_ok;

   dmem_lane_ctrl u_lane_ctrl (
      .size       (i_data_rd_en_ctrl),
      .offset     (i_data_addr[1:0]),
      .store_data (i_data_wr),
      .strobe     (strobe),
      .lane_data  (lane_data),
      .shift      (shift),
      .misaligned (misaligned)
   );

   // An address below BASE_ADDR wraps to a huge offset, so one upper-bits test
   // covers both ends of the window.
   assign rel_addr = i_data_addr - BASE_ADDR;
   assign in_range = (rel_addr[31:ADDR_WIDTH] == '0);
   assign word_idx = rel_addr[ADDR_WIDTH-1:2];
   assign req      = i_data_rd_en | i_data_wr_en;
   assign rsv      = (mem_size_t'(i_data_rd_en_ctrl) == MEM_RSV);

   assign o_access_fault = req & (rsv | ~in_range | misaligned);

   assign o_data_rd = (i_data_rd_en && !o_access_fault)
                    ? ((mem[word_idx] >> shift) & size_mask(mem_size_t'(i_data_rd_en_ctrl)))
                    : 32'h0000_0000;

   // Pipeline activity is held off for the first edge after reset release so a
   // store presented on that edge is dropped.
   // NOTE: sequential state is always assigned with non-blocking <= so every
   // flop samples pre-edge values regardless of block ordering.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) run <= 1'b0;
      else          run <= 1'b1;
   end

   assign active   = i_clk_en & run;
   assign load_ok  = active & i_data_rd_en & ~o_access_fault;
   assign store_ok = active & i_data_wr_en & ~o_access_fault;

   // NOTE: the RAM array has no reset; contents stay undefined until written,
   // which keeps it mappable onto block RAM.
   always_ff @(posedge i_clk) begin
      if (store_ok) begin
         for (int b = 0; b < 4; b++) begin
            if (strobe[b]) mem[word_idx][8*b +: 8] <= lane_data[8*b +: 8];
         end
      end
      // Later assignment wins, so the init port overrides a colliding store.
      if (i_init_we) mem[i_init_addr] <= i_init_data;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_fault_sticky <= 1'b0;
         o_fault_addr   <= 32'h0000_0000;
      end else if (active && o_access_fault) begin
         o_fault_sticky <= 1'b1;
         if (!o_fault_sticky || i_fault_clr) o_fault_addr <= i_data_addr;
      end else if (i_fault_clr) begin
         o_fault_sticky <= 1'b0;
         o_fault_addr   <= 32'h0000_0000;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_load_count  <= 16'h0000;
         o_store_count <= 16'h0000;
      end else begin
         if (load_ok && o_load_count != 16'hFFFF)   o_load_count  <= o_load_count + 16'd1;
         if (store_ok && o_store_count != 16'hFFFF) o_store_count <= o_store_count + 16'd1;
      end
   end

endmodule

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory: byte-array reference model, directed
// scenarios from the feature list and a randomized access mix.
module tb_data_memory;
   import riscv_pkg::*;

   localparam int          AW    = 12;
   localparam logic [31:0] BASE  = 32'h0000_0000;
   localparam int          BYTES = 4096;

   logic          i_clk = 1'b0;
   logic          i_rst_n = 1'b0;
   logic          i_clk_en = 1'b1;
   logic [31:0]   i_data_addr = '0;
   logic [31:0]   i_data_wr = '0;
   logic [1:0]    i_data_rd_en_ctrl = '0;
   logic          i_data_rd_en = 1'b0;
   logic          i_data_wr_en = 1'b0;
   logic [31:0]   o_data_rd;
   logic          o_access_fault;
   logic          o_fault_sticky;
   logic [31:0]   o_fault_addr;
   logic          i_fault_clr = 1'b0;
   logic [15:0]   o_load_count;
   logic [15:0]   o_store_count;
   logic          i_init_we = 1'b0;
   logic [AW-3:0] i_init_addr = '0;
   logic [31:0]   i_init_data = '0;

   always #5 i_clk = ~i_clk;

   data_memory #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE)) dut (
      .i_clk             (i_clk),
      .i_rst_n           (i_rst_n),
      .i_clk_en          (i_clk_en),
      .i_data_addr       (i_data_addr),
      .i_data_wr         (i_data_wr),
      .i_data_rd_en_ctrl (i_data_rd_en_ctrl),
      .i_data_rd_en      (i_data_rd_en),
      .i_data_wr_en      (i_data_wr_en),
      .o_data_rd         (o_data_rd),
      .o_access_fault    (o_access_fault),
      .o_fault_sticky    (o_fault_sticky),
      .o_fault_addr      (o_fault_addr),
      .i_fault_clr       (i_fault_clr),
      .o_load_count      (o_load_count),
      .o_store_count     (o_store_count),
      .i_init_we         (i_init_we),
      .i_init_addr       (i_init_addr),
      .i_init_data       (i_init_data)
   );

   // Reference model state.
   logic [7:0]  ref_mem [BYTES];
   int unsigned exp_loads = 0;
   int unsigned exp_stores = 0;
   logic        exp_sticky = 1'b0;
   logic [31:0] exp_faddr = '0;
   bit          model_active = 1'b1;

   int checks = 0;
   int errors = 0;

   function automatic logic m_fault(input logic [31:0] a, input logic [1:0] s,
                                    input logic r, input logic w);
      longint unsigned la = longint'(a);
      if (!(r || w)) return 1'b0;
      if (s == 2'b11) return 1'b1;
      if (la < longint'(BASE) || la >= longint'(BASE) + BYTES) return 1'b1;
      if (s == 2'b01 && a[0]) return 1'b1;
      if (s == 2'b10 && a[1:0] != 2'b00) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [31:0] m_read(input logic [31:0] a, input logic [1:0] s,
                                          input logic r, input logic w);
      logic [31:0] v = '0;
      int off = int'(a - BASE);
      if (!r || m_fault(a, s, r, w)) return 32'h0;
      for (int i = 0; i < (1 << s); i++) v = v | (32'(ref_mem[off + i]) << (8 * i));
      return v;
   endfunction

   task automatic drive(input logic [31:0] addr, input logic [1:0] size, input logic rd,
                        input logic wr, input logic [31:0] wdata, input logic ce);
      i_data_addr       = addr;
      i_data_rd_en_ctrl = size;
      i_data_rd_en      = rd;
      i_data_wr_en      = wr;
      i_data_wr         = wdata;
      i_clk_en          = ce;
      i_init_we         = 1'b0;
      i_fault_clr       = 1'b0;
      #1;
   endtask

   // Advance the model with the inputs currently applied, then clock the DUT.
   task automatic tick();
      logic f = m_fault(i_data_addr, i_data_rd_en_ctrl, i_data_rd_en, i_data_wr_en);
      int off = int'(i_data_addr - BASE);
      if (model_active && i_clk_en && !f) begin
         if (i_data_rd_en && exp_loads < 65535) exp_loads++;
         if (i_data_wr_en) begin
            for (int i = 0; i < (1 << i_data_rd_en_ctrl); i++) ref_mem[off + i] = i_data_wr[8*i +: 8];
            if (exp_stores < 65535) exp_stores++;
         end
      end
      if (model_active && i_clk_en && f) begin
         if (!exp_sticky || i_fault_clr) exp_faddr = i_data_addr;
         exp_sticky = 1'b1;
      end else if (model_active && i_fault_clr) begin
         exp_sticky = 1'b0;
         exp_faddr  = '0;
      end
      if (i_init_we) begin
         for (int i = 0; i < 4; i++) ref_mem[{i_init_addr, 2'b00} + i] = i_init_data[8*i +: 8];
      end
      @(posedge i_clk);
      #1;
   endtask

   task automatic test_reset();
      drive(32'h1, MEM_W, 1'b1, 1'b0, 32'h0, 1'b1);
      repeat (2) @(posedge i_clk);
      #1;
      checks++;
      if ({o_fault_sticky, o_fault_addr, o_load_count, o_store_count} !== 65'h0) begin
         errors++;
         $display("FAIL reset_status: got sticky=%b addr=%h ld=%h st=%h expected all zero",
                  o_fault_sticky, o_fault_addr, o_load_count, o_store_count);
      end
      checks++;
      if ({o_access_fault, o_data_rd} !== {1'b1, 32'h0}) begin
         errors++;
         $display("FAIL reset_comb_fault: got fault=%b data=%h expected fault=1 data=0",
                  o_access_fault, o_data_rd);
      end
      drive(32'h0, MEM_W, 1'b0, 1'b0, 32'h0, 1'b1);
      @(negedge i_clk);
      i_rst_n = 1'b1;
      repeat (2) @(posedge i_clk);
      #1;
   endtask

   task automatic test_preload();
      for (int w = 0; w < BYTES / 4; w++) begin
         drive(32'h0, MEM_W, 1'b0, 1'b0, 32'h0, 1'b1);
         i_init_we   = 1'b1;
         i_init_addr = (AW-2)'(w);
         i_init_data = (w == 0) ? 32'hA1B2_C3D4 : $urandom;
         tick();
      end
      i_init_we = 1'b0;
   endtask

   task automatic test_loads();
      logic [31:0] addrs [3] = '{32'h0, 32'h2, 32'h1};
      logic [1:0]  sizes [3] = '{MEM_W, MEM_H, MEM_B};
      logic [31:0] plan  [3] = '{32'hA1B2_C3D4, 32'h0000_A1B2, 32'h0000_00C3};
      for (int i = 0; i < 3; i++) begin
         drive(addrs[i], sizes[i], 1'b1, 1'b0, 32'h0, 1'b1);
         checks++;
         if (o_data_rd !== plan[i] || o_data_rd !== m_read(addrs[i], sizes[i], 1'b1, 1'b0)) begin
            errors++;
            $display("FAIL load_%0d: got %h expected %h", i, o_data_rd, plan[i]);
         end
         tick();
      end
      checks++;
      if (o_load_count !== 16'd3) begin
         errors++;
         $display("FAIL load_count: got %0d expected 3", o_load_count);
      end
   endtask

   task automatic test_store_b();
      drive(32'h3, MEM_B, 1'b1, 1'b1, 32'hFFFF_FF5A, 1'b1);
      checks++;
      if (o_data_rd !== 32'h0000_00A1) begin
         errors++;
         $display("FAIL rdw_byte_old: got %h expected 000000a1", o_data_rd);
      end
      tick();
      checks++;
      if (o_store_count !== 16'd1) begin
         errors++;
         $display("FAIL store_count: got %0d expected 1", o_store_count);
      end
      drive(32'h0, MEM_W, 1'b1, 1'b1, 32'h1234_5678, 1'b1);
      checks++;
      if (o_data_rd !== 32'h5AB2_C3D4) begin
         errors++;
         $display("FAIL rdw_word_old: got %h expected 5ab2c3d4", o_data_rd);
      end
      tick();
      drive(32'h0, MEM_W, 1'b1, 1'b0, 32'h0, 1'b1);
      checks++;
      if (o_data_rd !== 32'h1234_5678) begin
         errors++;
         $display("FAIL store_visible: got %h expected 12345678", o_data_rd);
      end
      tick();
   endtask

   task automatic test_fault_sticky();
      drive(32'h1, MEM_H, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1);
      checks++;
      if (o_access_fault !== 1'b1) begin
         errors++;
         $display("FAIL misaligned_h_fault: got %b expected 1", o_access_fault);
      end
      tick();
      checks++;
      if ({o_fault_sticky, o_fault_addr} !== {1'b1, 32'h1}) begin
         errors++;
         $display("FAIL sticky_first: got %b/%h expected 1/00000001", o_fault_sticky, o_fault_addr);
      end
      drive(32'h0, MEM_W, 1'b1, 1'b0, 32'h0, 1'b1);
      checks++;
      if (o_data_rd !== m_read(32'h0, MEM_W, 1'b1, 1'b0)) begin
         errors++;
         $display("FAIL suppressed_store: got %h expected %h", o_data_rd, m_read(32'h0, MEM_W, 1'b1, 1'b0));
      end
      tick();
      drive(32'h2000, MEM_B, 1'b1, 1'b0, 32'h0, 1'b1);
      tick();
      checks++;
      if (o_fault_addr !== 32'h1) begin
         errors++;
         $display("FAIL first_fault_kept: got %h expected 00000001", o_fault_addr);
      end
      drive(32'h3000, MEM_B, 1'b1, 1'b0, 32'h0, 1'b1);
      i_fault_clr = 1'b1;
      tick();
      checks++;
      if ({o_fault_sticky, o_fault_addr} !== {1'b1, 32'h3000}) begin
         errors++;
         $display("FAIL fault_beats_clear: got %b/%h expected 1/00003000", o_fault_sticky, o_fault_addr);
      end
      drive(32'h0, MEM_B, 1'b0, 1'b0, 32'h0, 1'b0);
      i_fault_clr = 1'b1;
      tick();
      checks++;
      if ({o_fault_sticky, o_fault_addr} !== 33'h0) begin
         errors++;
         $display("FAIL fault_clear: got %b/%h expected 0/00000000", o_fault_sticky, o_fault_addr);
      end
   endtask

   task automatic test_boundaries();
      logic [31:0] addrs [7] = '{32'hFFF, 32'hFFE, 32'hFFC, 32'h1000, 32'hFFFF_FFFF, 32'h6, 32'hFFD};
      logic [1:0]  sizes [7] = '{MEM_B, MEM_H, MEM_W, MEM_B, MEM_B, MEM_W, MEM_H};
      for (int i = 0; i < 7; i++) begin
         drive(addrs[i], sizes[i], 1'b1, 1'b0, 32'h0, 1'b1);
         checks++;
         if ({o_access_fault, o_data_rd} !== {m_fault(addrs[i], sizes[i], 1'b1, 1'b0),
                                               m_read(addrs[i], sizes[i], 1'b1, 1'b0)}) begin
            errors++;
            $display("FAIL boundary_%0d: got fault=%b data=%h expected fault=%b data=%h", i,
                     o_access_fault, o_data_rd, m_fault(addrs[i], sizes[i], 1'b1, 1'b0),
                     m_read(addrs[i], sizes[i], 1'b1, 1'b0));
         end
         tick();
      end
      drive(32'h0, MEM_B, 1'b0, 1'b0, 32'h0, 1'b1);
      i_fault_clr = 1'b1;
      tick();
   endtask

   task automatic test_rsv_and_clk_en();
      logic [15:0] ld_before = 16'(exp_loads);
      drive(32'h0, MEM_RSV, 1'b1, 1'b0, 32'h0, 1'b1);
      checks++;
      if ({o_access_fault, o_data_rd} !== {1'b1, 32'h0}) begin
         errors++;
         $display("FAIL rsv_load: got fault=%b data=%h expected fault=1 data=0", o_access_fault, o_data_rd);
      end
      tick();
      checks++;
      if (o_load_count !== ld_before) begin
         errors++;
         $display("FAIL rsv_no_count: got %0d expected %0d", o_load_count, ld_before);
      end
      drive(32'h0, MEM_B, 1'b0, 1'b0, 32'h0, 1'b1);
      i_fault_clr = 1'b1;
      tick();
      drive(32'h4, MEM_W, 1'b1, 1'b1, 32'hCAFE_F00D, 1'b0);
      tick();
      drive(32'h4, MEM_W, 1'b1, 1'b0, 32'h0, 1'b0);
      checks++;
      if (o_data_rd !== m_read(32'h4, MEM_W, 1'b1, 1'b0)) begin
         errors++;
         $display("FAIL clk_en_gates_store: got %h expected %h", o_data_rd, m_read(32'h4, MEM_W, 1'b1, 1'b0));
      end
      tick();
      checks++;
      if ({o_load_count, o_store_count} !== {16'(exp_loads), 16'(exp_stores)}) begin
         errors++;
         $display("FAIL clk_en_counters: got %0d/%0d expected %0d/%0d",
                  o_load_count, o_store_count, exp_loads, exp_stores);
      end
   endtask

   task automatic test_init_collision();
      drive(32'h4, MEM_W, 1'b0, 1'b1, 32'h1111_2222, 1'b1);
      i_init_we   = 1'b1;
      i_init_addr = (AW-2)'(1);
      i_init_data = 32'h7E57_0001;
      tick();
      drive(32'h4, MEM_W, 1'b1, 1'b0, 32'h0, 1'b1);
      checks++;
      if (o_data_rd !== 32'h7E57_0001) begin
         errors++;
         $display("FAIL init_wins: got %h expected 7e570001", o_data_rd);
      end
      tick();
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         logic [31:0] a = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, BYTES - 1));
         drive(a, 2'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), $urandom,
               ($urandom_range(0, 7) != 0));
         i_fault_clr = ($urandom_range(0, 15) == 0);
         i_init_we   = ($urandom_range(0, 15) == 0);
         i_init_addr = (AW-2)'($urandom);
         i_init_data = $urandom;
         checks++;
         if ({o_access_fault, o_data_rd} !== {m_fault(a, i_data_rd_en_ctrl, i_data_rd_en, i_data_wr_en),
                                               m_read(a, i_data_rd_en_ctrl, i_data_rd_en, i_data_wr_en)}) begin
            errors++;
            $display("FAIL random_comb_%0d: addr=%h got fault=%b data=%h expected fault=%b data=%h", n, a,
                     o_access_fault, o_data_rd, m_fault(a, i_data_rd_en_ctrl, i_data_rd_en, i_data_wr_en),
                     m_read(a, i_data_rd_en_ctrl, i_data_rd_en, i_data_wr_en));
         end
         tick();
         checks++;
         if ({o_fault_sticky, o_fault_addr, o_load_count, o_store_count} !==
             {exp_sticky, exp_faddr, 16'(exp_loads), 16'(exp_stores)}) begin
            errors++;
            $display("FAIL random_status_%0d: got %b/%h/%0d/%0d expected %b/%h/%0d/%0d", n,
                     o_fault_sticky, o_fault_addr, o_load_count, o_store_count,
                     exp_sticky, exp_faddr, exp_loads, exp_stores);
         end
      end
   endtask

   task automatic test_saturation();
      for (int n = 0; n < 65540; n++) begin
         drive(32'h100 + 32'(n % 64), MEM_B, 1'b0, 1'b1, 32'(n), 1'b1);
         tick();
      end
      checks++;
      if (o_store_count !== 16'hFFFF || exp_stores != 65535) begin
         errors++;
         $display("FAIL store_saturate: got %h expected ffff", o_store_count);
      end
   endtask

   task automatic test_reset_mid();
      drive(32'h5, MEM_W, 1'b0, 1'b1, 32'h0, 1'b1);
      tick();
      drive(32'h8, MEM_W, 1'b0, 1'b1, 32'hBAD0_0008, 1'b1);
      #2;
      i_rst_n = 1'b0;
      model_active = 1'b0;
      exp_sticky = 1'b0;
      exp_faddr  = '0;
      exp_loads  = 0;
      exp_stores = 0;
      #1;
      checks++;
      if ({o_fault_sticky, o_fault_addr, o_load_count, o_store_count} !== 65'h0) begin
         errors++;
         $display("FAIL async_reset: got %b/%h/%0d/%0d expected all zero",
                  o_fault_sticky, o_fault_addr, o_load_count, o_store_count);
      end
      tick();
      @(negedge i_clk);
      i_rst_n = 1'b1;
      tick();
      model_active = 1'b1;
      drive(32'h8, MEM_W, 1'b1, 1'b0, 32'h0, 1'b1);
      checks++;
      if (o_data_rd !== m_read(32'h8, MEM_W, 1'b1, 1'b0) || o_store_count !== 16'h0) begin
         errors++;
         $display("FAIL release_store_dropped: got %h/%0d expected %h/0",
                  o_data_rd, o_store_count, m_read(32'h8, MEM_W, 1'b1, 1'b0));
      end
      tick();
      for (int i = 0; i < 4; i++) begin
         logic [31:0] a = 32'($urandom_range(0, BYTES / 4 - 1)) << 2;
         drive(a, MEM_W, 1'b1, 1'b0, 32'h0, 1'b1);
         checks++;
         if (o_data_rd !== m_read(a, MEM_W, 1'b1, 1'b0)) begin
            errors++;
            $display("FAIL post_reset_read_%0d: got %h expected %h", i, o_data_rd, m_read(a, MEM_W, 1'b1, 1'b0));
         end
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_preload();
      test_loads();
      test_store_b();
      test_fault_sticky();
      test_boundaries();
      test_rsv_and_clk_en();
      test_init_collision();
      test_random();
      test_saturation();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/data_memory.md
Name: data_memory

Overview:
Byte-addressable data RAM that serves as the responder to the pipeline's memory-access stage.
- Accepts address, store data, read/write enables and access size (00=B, 01=H, 10=W).
- Returns load data combinationally, right-justified with upper bits zero. The MEM stage performs sign/zero extension.
- Performs byte-lane stores on the clock edge, and reports access faults, sticky fault status and load/store counters.
- Also provides a word-wide init port so benches and boot logic can preload contents.

Parameters:
ADDR_WIDTH, 12, byte-address bits of the RAM (2^ADDR_WIDTH bytes, 4 KiB)
BASE_ADDR, 32'h0000_0000, first byte address mapped to the RAM (aligned to 2^ADDR_WIDTH)

Ports:
i_clk  input  1  system clock
i_rst_n  input  1  asynchronous active-low reset
i_clk_en  input  1  pipeline clock enable; gates stores, fault capture and counters
i_data_addr  input  32  byte address
i_data_wr  input  32  store data; low bytes used per size
i_data_rd_en_ctrl  input  2  access size: 00=B, 01=H, 10=W, 11=reserved
i_data_rd_en  input  1  load request
i_data_wr_en  input  1  store request
o_data_rd  output  32  load data, right-justified, upper bits zero
o_access_fault  output  1  combinational fault indication for the current request
o_fault_sticky  output  1  latched fault flag
o_fault_addr  output  32  address of the first fault since the last clear
i_fault_clr  input  1  clears the sticky flag and fault address
o_load_count  output  16  saturating count of successful loads
o_store_count  output  16  saturating count of successful stores
i_init_we  input  1  init word write
i_init_addr  input  ADDR_WIDTH-2  init word index
i_init_data  input  32  init word data

Behaviour:
Interface:
- One clock, i_clk; reset i_rst_n is asynchronous, active-low.

Reset:
- Registers: o_fault_sticky=0, o_fault_addr=0, o_load_count=0, o_store_count=0.
- RAM array is not reset; contents are undefined until written or preloaded.

Combinational outputs:
- o_data_rd and o_access_fault are combinational, so they are valid in reset as well.

Fault condition (req = rd_en | wr_en):
- Fault = req AND (ctrl==11 OR out-of-range OR misaligned).
- Out-of-range: address is outside [BASE_ADDR, BASE_ADDR + 2^ADDR_WIDTH). Compare the full 32 bits, not just the low bits.
- Misaligned: H with addr[0]=1, or W with addr[1:0]!=0. Byte accesses are never misaligned.

Reads (zero latency, combinational):
- If rd_en is high and there is no fault, with a = addr - BASE_ADDR:
  - B returns {24'b0, mem[a]}
  - H returns {16'b0, mem[a+1], mem[a]}
  - W returns {mem[a+3], mem[a+2], mem[a+1], mem[a]} (little-endian)
- In every other case, o_data_rd = 0.

Writes (on posedge when i_clk_en=1, wr_en=1 and no fault):
- B writes i_data_wr[7:0] to byte a.
- H writes [15:0] to bytes a..a+1.
- W writes [31:0] to bytes a..a+3.
- Any faulting store is suppressed entirely; no partial write occurs.
- With i_clk_en=0, no store is performed.

Read-during-write:
- A load in the same cycle as a store returns the pre-edge contents.
- A store becomes visible to reads in the cycle after the edge.
- rd_en and wr_en both high is legal: the store is performed, the read returns old data, and both counters increment.

Init port:
- i_init_we writes a full word at word index i_init_addr on posedge, independent of i_clk_en.
- If a pipeline store in the same cycle hits the same word, the init port wins on all four bytes.
- Init writes are not counted.

Counters:
- On posedge with i_clk_en=1, each counter increments for a non-faulting load (respectively store).
- Both counters saturate at 16'hFFFF; no wrap.

Sticky fault:
- On posedge with i_clk_en=1 and o_access_fault=1: set o_fault_sticky.
- o_fault_addr captures i_data_addr only if the sticky flag was 0 (first fault is kept).
- i_fault_clr clears both the flag and the address. It acts independently of i_clk_en.
- If a fault and a clear occur on the same edge, the set wins and the address is recaptured.

Reset mid-operation:
- Asserting reset clears status immediately, without waiting for a clock edge.
- A store on the same edge as the reset release is dropped.

Decomposition:
- Shared package riscv_pkg: typedef mem_size_t enum logic[1:0] with MEM_B=2'b00, MEM_H=2'b01, MEM_W=2'b10, MEM_RSV=2'b11. The MEM stage and this block both use it.
- One natural sub-module, dmem_lane_ctrl (combinational). From size, addr[1:0] and store data it produces the 4-bit byte-write strobe, the lane-shifted write data, and the misaligned flag. The read path reuses its offset for right-justification.

Test Plan:
- Init word idx 0 = 32'hA1B2_C3D4; load W @0 -> 32'hA1B2C3D4; load H @2 -> 32'h0000A1B2; load B @1 -> 32'h000000C3; o_load_count=3.
- Store B 32'hFFFF_FF5A @3 over the preloaded word -> subsequent load W @0 = 32'h5AB2C3D4; same-cycle load W @0 returns 32'hA1B2C3D4; o_store_count=1.
- Store H @1 -> o_access_fault=1, word unchanged; o_fault_sticky=1, o_fault_addr=1. A later fault at @0x2000 (out of range) leaves o_fault_addr=1. i_fault_clr -> sticky=0, addr=0.
- ctrl=11 load @0 -> o_data_rd=0, fault=1, o_load_count unchanged; i_clk_en=0 store W @4 -> word 1 unchanged, counters hold.
- Init we to idx 1 plus pipeline store W @4 in the same cycle -> word 1 equals init data. Force o_store_count to 16'hFFFF via repeated stores -> stays 16'hFFFF.
- Assert i_rst_n low mid-burst -> status outputs 0 asynchronously; preloaded RAM contents are still readable after reset.
